// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared types and helpers for the data-memory access unit.
//   state_t      : access FSM states (IDLE, RD, WR, RESP)
//   SZ_*         : request size codes (2'b11 is handled as a word)
//   LANE_BITS    : number of byte-offset bits inside a 32-bit word
//   is_sub_word  : true for byte/half sizes
//   is_misaligned: true when a half/word is not naturally aligned
//   align_offset : byte offset actually used once alignment is forced
// ---------------------------------------------------------------------------
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LANE_BITS = 2;

    function automatic logic is_sub_word(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [LANE_BITS-1:0] offset);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

    // Half accesses ignore offset bit 0, words ignore both offset bits.
    function automatic logic [LANE_BITS-1:0] align_offset(input logic [1:0] size,
                                                          input logic [LANE_BITS-1:0] offset);
        logic [LANE_BITS-1:0] off;
        case (size)
            SZ_BYTE: off = offset;
            SZ_HALF: off = {offset[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane logic for a little-endian 32-bit word.
//   size        in  : request size code
//   is_unsigned in  : 1 = zero-extend sub-word loads, 0 = sign-extend
//   offset      in  : aligned byte offset within the word
//   mem_word    in  : word read from memory
//   store_data  in  : right-aligned store data
//   load_data   out : extracted and extended load result
//   merged_data out : mem_word with the addressed lane(s) replaced
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]           size,
    input  logic                 is_unsigned,
    input  logic [LANE_BITS-1:0] offset,
    input  logic [W-1:0]         mem_word,
    input  logic [W-1:0]         store_data,
    output logic [W-1:0]         load_data,
    output logic [W-1:0]         merged_data
);

    logic [4:0]   byte_sh_s;
    logic [4:0]   half_sh_s;
    logic [W-1:0] byte_word_s;
    logic [W-1:0] half_word_s;
    logic [7:0]   byte_s;
    logic [15:0]  half_s;
    logic [W-1:0] byte_mask_s;
    logic [W-1:0] half_mask_s;

    // Lane selection: byte k lives in bits [8k+7:8k], half uses lane offset[1]*16.
    always_comb begin
        byte_sh_s   = {offset, 3'b000};
        half_sh_s   = {offset[1], 4'b0000};
        byte_word_s = mem_word >> byte_sh_s;
        half_word_s = mem_word >> half_sh_s;
        byte_s      = byte_word_s[7:0];
        half_s      = half_word_s[15:0];
        byte_mask_s = {{(W-8){1'b0}}, 8'hFF} << byte_sh_s;
        half_mask_s = {{(W-16){1'b0}}, 16'hFFFF} << half_sh_s;
    end

    // Load path: extract the lane and extend it to a full word.
    always_comb begin
        load_data = mem_word;
        case (size)
            SZ_BYTE: begin
                if (is_unsigned) begin
                    load_data = {{(W-8){1'b0}}, byte_s};
                end else begin
                    load_data = {{(W-8){byte_s[7]}}, byte_s};
                end
            end
            SZ_HALF: begin
                if (is_unsigned) begin
                    load_data = {{(W-16){1'b0}}, half_s};
                end else begin
                    load_data = {{(W-16){half_s[15]}}, half_s};
                end
            end
            default: load_data = mem_word;
        endcase
    end

    // Store path: replace only the addressed lane(s), keep the rest of the word.
    always_comb begin
        merged_data = store_data;
        case (size)
            SZ_BYTE: merged_data = (mem_word & ~byte_mask_s)
                                 | (({{(W-8){1'b0}}, store_data[7:0]} << byte_sh_s) & byte_mask_s);
            SZ_HALF: merged_data = (mem_word & ~half_mask_s)
                                 | (({{(W-16){1'b0}}, store_data[15:0]} << half_sh_s) & half_mask_s);
            default: merged_data = store_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Initiator side of the data-memory port. Takes one load/store at a time
// over valid/ready, drives a word-organised RAM, extracts/extends load data
// and performs sub-word stores as read-modify-write.
//
// Build option: define MISALIGN_TRAP_EN to answer misaligned half/word
// accesses with resp_err=1 and no memory cycle. Without it the low address
// bits are ignored for half/word and resp_err is tied to 0.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready only when idle)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                 request fields, latched on accept
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_err      load result / misalignment flag
//   MemWrite, MemRead         memory enables (never both high)
//   address                   word address to memory
//   write_data                merged word to memory
//   read_data                 combinational memory read data
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [N-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         resp_valid,
    output logic [W-1:0] resp_rdata,
    output logic         resp_err,
    output logic         MemWrite,
    output logic         MemRead,
    output logic [N-1:0] address,
    output logic [W-1:0] write_data,
    input  logic [W-1:0] read_data
);

    state_t               state_r;
    state_t               state_next_s;
    logic                 accept_s;
    logic                 misalign_s;
    logic                 we_r;
    logic [1:0]           size_r;
    logic                 uns_r;
    logic [LANE_BITS-1:0] off_r;
    logic [N-1:0]         address_r;
    logic [W-1:0]         write_data_r;
    logic [W-1:0]         resp_rdata_r;
    logic [W-1:0]         load_s;
    logic [W-1:0]         merged_s;

    assign accept_s = req_valid && (state_r == IDLE);

`ifdef MISALIGN_TRAP_EN
    logic resp_err_r;
    assign misalign_s = is_misaligned(req_size, req_addr[LANE_BITS-1:0]);
    assign resp_err   = resp_err_r;
`else
    assign misalign_s = 1'b0;
    assign resp_err   = 1'b0;
`endif

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (misalign_s) begin
                        state_next_s = RESP;
                    end else if (req_we && !is_sub_word(req_size)) begin
                        state_next_s = WR;
                    end else begin
                        state_next_s = RD;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD: begin
                if (we_r) begin
                    state_next_s = WR;
                end else begin
                    state_next_s = RESP;
                end
            end
            WR:      state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Control outputs decode from the state register only, so they fall
    // together with the asynchronous reset and never see req_* directly.
    always_comb begin
        req_ready  = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        resp_valid = 1'b0;
        case (state_r)
            IDLE:    req_ready  = 1'b1;
            RD:      MemRead    = 1'b1;
            WR:      MemWrite   = 1'b1;
            RESP:    resp_valid = 1'b1;
            default: req_ready  = 1'b0;
        endcase
    end

    mem_lane_align #(
        .W (W)
    ) u_lane_align (
        .size        (size_r),
        .is_unsigned (uns_r),
        .offset      (off_r),
        .mem_word    (read_data),
        .store_data  (write_data_r),
        .load_data   (load_s),
        .merged_data (merged_s)
    );

    // Request latch and datapath. write_data_r first holds the raw store
    // data; for sub-word stores it is replaced by the merged word in RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r         <= 1'b0;
            size_r       <= SZ_WORD;
            uns_r        <= 1'b0;
            off_r        <= 2'b00;
            address_r    <= {N{1'b0}};
            write_data_r <= {W{1'b0}};
            resp_rdata_r <= {W{1'b0}};
`ifdef MISALIGN_TRAP_EN
            resp_err_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r         <= req_we;
                        size_r       <= req_size;
                        uns_r        <= req_unsigned;
                        off_r        <= align_offset(req_size, req_addr[LANE_BITS-1:0]);
                        address_r    <= {2'b00, req_addr[N-1:LANE_BITS]};
                        write_data_r <= req_wdata;
                        resp_rdata_r <= {W{1'b0}};
`ifdef MISALIGN_TRAP_EN
                        resp_err_r   <= misalign_s;
`endif
                    end
                end
                RD: begin
                    if (we_r) begin
                        write_data_r <= merged_s;
                    end else begin
                        resp_rdata_r <= load_s;
                    end
                end
                default: begin
                    we_r <= we_r;
                end
            endcase
        end
    end

    assign address    = address_r;
    assign write_data = write_data_r;
    assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench: directed scenarios plus randomized load/store traffic
// compared against a word-array reference model of memory contents.
// Unwritten RAM word i holds the value i.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    logic        ram_clear;
    logic [31:0] ram  [0:1023];
    logic [31:0] refm [0:1023];

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_unit #(.N(32), .W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench RAM: combinational read, synchronous write.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'(i);
        end else if (MemWrite) begin
            ram[address[9:0]] <= write_data;
        end
    end
    assign read_data = ram[address[9:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_trap(input logic [1:0] size, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        if (size == 2'd0) return 1'b0;
        if (size == 2'd1) return addr[0];
        return (addr[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Reference load: pick the byte/half/word by arithmetic on the byte address.
    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
        logic [31:0] word, v;
        int bytepos;
        word = refm[addr[11:2]];
        if (size == 2'd0) begin
            bytepos = int'(addr % 4);
            v = (word >> (8 * bytepos)) & 32'h0000_00FF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            bytepos = int'((addr % 4) / 2) * 2;
            v = (word >> (8 * bytepos)) & 32'h0000_FFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Reference store: the word the RAM should hold afterwards.
    function automatic logic [31:0] ref_store(input logic [1:0] size, input logic [31:0] addr,
                                              input logic [31:0] wdata);
        logic [31:0] word, keep;
        int bytepos;
        word = refm[addr[11:2]];
        if (size == 2'd0) begin
            bytepos = int'(addr % 4);
            keep = ~(32'h0000_00FF << (8 * bytepos));
            return (word & keep) | ((wdata & 32'h0000_00FF) << (8 * bytepos));
        end else if (size == 2'd1) begin
            bytepos = int'((addr % 4) / 2) * 2;
            keep = ~(32'h0000_FFFF << (8 * bytepos));
            return (word & keep) | ((wdata & 32'h0000_FFFF) << (8 * bytepos));
        end
        return wdata;
    endfunction

    // One complete request; called at a negedge, returns at a negedge.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_rdata, output logic [31:0] got_wdata);
        logic trap, sub, seen, got_err, both;
        int lat, nrd, nwr, exp_lat, exp_rd, exp_wr;
        logic [31:0] exp_data, exp_word;
        sub  = (size == 2'd0) || (size == 2'd1);
        trap = is_trap(size, addr);
        exp_lat  = trap ? 1 : ((we && sub) ? 3 : 2);
        exp_rd   = trap ? 0 : ((we && !sub) ? 0 : 1);
        exp_wr   = (we && !trap) ? 1 : 0;
        exp_data = (we || trap) ? 32'h0 : ref_load(size, uns, addr);
        exp_word = ref_store(size, addr, wdata);
        got_rdata = 32'h0; got_wdata = 32'h0; got_err = 1'b0;
        seen = 1'b0; both = 1'b0; lat = 0; nrd = 0; nwr = 0;

        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
                req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            end
            if (MemRead && MemWrite) both = 1'b1;
            if (MemRead) begin
                nrd++;
                check("rd_address", address, addr >> 2);
            end
            if (MemWrite) begin
                nwr++;
                got_wdata = write_data;
                check("wr_address", address, addr >> 2);
            end
            if (resp_valid) begin
                seen = 1'b1; lat = c; got_rdata = resp_rdata; got_err = resp_err;
            end
        end
        check("resp_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("memread_cycles", 32'(nrd), 32'(exp_rd));
        check("memwrite_cycles", 32'(nwr), 32'(exp_wr));
        check("rd_wr_overlap", 32'(both), 32'd0);
        check("resp_err", 32'(got_err), 32'(trap));
        check("resp_rdata", got_rdata, exp_data);
        if (we && !trap) begin
            check("write_data", got_wdata, exp_word);
            refm[addr[11:2]] = exp_word;
        end
        @(negedge clk);
        check("resp_pulse_width", 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] rd, wd;
    logic        rdy;
    int          k, nresp, npulse;
    int          acc [3];
    logic [31:0] a6 [3];
    logic [31:0] e6 [3];

    initial begin
        for (int i = 0; i < 1024; i++) refm[i] = 32'(i);
        rst = 1'b1; ram_clear = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_address", address, 32'h0);
        check("rst_write_data", write_data, 32'h0);
        rst = 1'b0; ram_clear = 1'b0;
        @(negedge clk);

        // Directed scenarios.
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0, rd, wd);
        check("t1_word_load", rd, 32'h0000_0003);
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, rd, wd);
        check("t2_word_store_data", wd, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, rd, wd);
        check("t2_word_load", rd, 32'hDEAD_BEEF);
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_0080, rd, wd);
        check("t3_byte_merge", wd, 32'hDEAD_80EF);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0, rd, wd);
        check("t3_byte_signed", rd, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0101, 32'h0, rd, wd);
        check("t3_byte_unsigned", rd, 32'h0000_0080);
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, rd, wd);
        check("t3_half_signed", rd, 32'hFFFF_DEAD);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0, rd, wd);
`ifdef MISALIGN_TRAP_EN
        check("t4_misaligned_word", rd, 32'h0);
`else
        check("t4_misaligned_word", rd, 32'hDEAD_80EF);
`endif

        // Randomized traffic in a small window so loads hit earlier stores.
        for (int t = 0; t < 150; t++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   32'h0000_0200 + 32'($urandom_range(0, 63)), $urandom, rd, wd);
        end

        // Reset during WR aborts the write and suppresses the response.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0000_0300;
        req_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("t5_memwrite_in_wr", 32'(MemWrite), 32'd1);
        #2 rst = 1'b1;
        #1 check("t5_memwrite_on_rst", 32'(MemWrite), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t5_ready_after_rst", 32'(req_ready), 32'd1);
        npulse = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid) npulse++;
        end
        check("t5_no_resp", 32'(npulse), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, rd, wd);
        check("t5_write_aborted", rd, 32'h0000_00C0);

        // Back-to-back loads with req_valid held high.
        a6[0] = 32'h0000_0100; a6[1] = 32'h0000_0300; a6[2] = 32'h0000_000C;
        for (int i = 0; i < 3; i++) e6[i] = ref_load(2'd2, 1'b0, a6[i]);
        k = 0; nresp = 0;
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        for (int c = 0; c < 30 && nresp < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (resp_valid) begin
                if (nresp < 3) check("t6_data_order", resp_rdata, e6[nresp]);
                nresp++;
            end
            req_valid = (k < 3);
            req_addr  = a6[(k < 3) ? k : 2];
            rdy = req_ready;
            @(posedge clk);
            if (rdy && req_valid) begin
                acc[k] = c;
                k++;
            end
        end
        req_valid = 1'b0;
        check("t6_resp_count", 32'(nresp), 32'd3);
        check("t6_accept_count", 32'(k), 32'd3);
        check("t6_gap_1", 32'(acc[1] - acc[0]), 32'd3);
        check("t6_gap_2", 32'(acc[2] - acc[1]), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
